// File: rtl/n64_bus_router_pkg.sv
// Shared definitions for the N64 PI bus router: device IDs, FSM states and the
// default address map used when no REGION_BASE/REGION_MASK override is given.
package sc64;

  localparam int MAX_DEVICES = 16;

  typedef enum logic [3:0] {
    DEV_CART_ROM    = 4'd0,
    DEV_SC64_REGS   = 4'd1,
    DEV_FLASH       = 4'd2,
    DEV_SC64_BUFFER = 4'd3,
    DEV_SRAM        = 4'd4,
    DEV_DD          = 4'd5
  } device_id_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DISPATCH,
    ST_WAIT,
    ST_RESPOND
  } state_t;

  // Index 3 is a 4 KiB window inside region 1, so the two overlap on purpose.
  // Unused slots (6..15) have a zero mask and an all-ones base and never match.
  localparam logic [MAX_DEVICES-1:0][31:0] DEFAULT_REGION_BASE = {
    {10{32'hFFFF_FFFF}},
    32'h0500_0000,
    32'h0800_0000,
    32'h1FFF_0000,
    32'h1800_0000,
    32'h1FFF_0000,
    32'h1000_0000
  };

  localparam logic [MAX_DEVICES-1:0][31:0] DEFAULT_REGION_MASK = {
    {10{32'h0000_0000}},
    32'hFF00_0000,
    32'hFF00_0000,
    32'hFFFF_F000,
    32'hFC00_0000,
    32'hFFFF_0000,
    32'hFC00_0000
  };

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/n64_bus_decoder.sv
// Combinational region decoder: the lowest-indexed enabled region whose masked
// address equals its base wins.
module n64_bus_decoder
  import sc64::*;
#(
  parameter int NUM_DEVICES = 6,
  parameter logic [NUM_DEVICES-1:0][31:0] REGION_BASE = DEFAULT_REGION_BASE[NUM_DEVICES-1:0],
  parameter logic [NUM_DEVICES-1:0][31:0] REGION_MASK = DEFAULT_REGION_MASK[NUM_DEVICES-1:0],
  localparam int IDX_W = idx_width(NUM_DEVICES)
) (
  input  logic [31:0]            address,
  input  logic [NUM_DEVICES-1:0] enable,
  output logic [NUM_DEVICES-1:0] match,
  output logic [IDX_W-1:0]       index,
  output logic                   hit
);

  logic [NUM_DEVICES-1:0] raw_match;

  always_comb begin
    raw_match = '0;
    for (int i = 0; i < NUM_DEVICES; i++) begin
      raw_match[i] = enable[i] && ((address & REGION_MASK[i]) == REGION_BASE[i]);
    end
  end

  // Scan from the top down so the last assignment is the lowest match.
  always_comb begin
    match = '0;
    index = '0;
    hit   = 1'b0;
    for (int i = NUM_DEVICES - 1; i >= 0; i--) begin
      if (raw_match[i]) begin
        match    = '0;
        match[i] = 1'b1;
        index    = IDX_W'(i);
        hit      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/n64_bus_router.sv
// Routes single-cycle PI accesses to one of NUM_DEVICES devices, waits for the
// device ack with a timeout, and answers unmapped or timed-out reads with open bus.
module n64_bus_router
  import sc64::*;
#(
  parameter int NUM_DEVICES    = 6,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [NUM_DEVICES-1:0][31:0] REGION_BASE = DEFAULT_REGION_BASE[NUM_DEVICES-1:0],
  parameter logic [NUM_DEVICES-1:0][31:0] REGION_MASK = DEFAULT_REGION_MASK[NUM_DEVICES-1:0]
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_DEVICES-1:0]       dev_enable,
  input  logic                         up_request,
  input  logic                         up_write,
  input  logic [31:0]                  up_address,
  input  logic [15:0]                  up_wdata,
  output logic                         up_ack,
  output logic [15:0]                  up_rdata,
  output logic                         up_busy,
  output logic [NUM_DEVICES-1:0]       dev_request,
  output logic                         dev_write,
  output logic [31:0]                  dev_address,
  output logic [15:0]                  dev_wdata,
  input  logic [NUM_DEVICES-1:0]       dev_ack,
  input  logic [NUM_DEVICES-1:0][15:0] dev_rdata,
  output logic [15:0]                  timeout_count
);

  localparam int IDX_W = idx_width(NUM_DEVICES);
  localparam logic [15:0] TIMER_LOAD = 16'(TIMEOUT_CYCLES);

  state_t                 state_q, state_d;
  logic                   write_q, write_d;
  logic [31:0]            address_q, address_d;
  logic [15:0]            wdata_q, wdata_d;
  logic [NUM_DEVICES-1:0] match_q, match_d;
  logic [IDX_W-1:0]       sel_q, sel_d;
  logic                   hit_q, hit_d;
  logic [15:0]            timer_q, timer_d;
  logic [15:0]            rdata_q, rdata_d;
  logic [15:0]            timeout_count_q, timeout_count_d;

  logic [NUM_DEVICES-1:0] dec_match;
  logic [IDX_W-1:0]       dec_index;
  logic                   dec_hit;
  logic                   sel_ack;
  logic [15:0]            sel_rdata;
  logic [15:0]            open_bus;

  n64_bus_decoder #(
    .NUM_DEVICES (NUM_DEVICES),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK)
  ) u_decoder (
    .address (up_address),
    .enable  (dev_enable),
    .match   (dec_match),
    .index   (dec_index),
    .hit     (dec_hit)
  );

  // Only the selected port is listened to; acks on other ports are ignored.
  assign sel_ack   = dev_ack[sel_q];
  assign sel_rdata = dev_rdata[sel_q];
  assign open_bus  = write_q ? 16'h0000 : address_q[15:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (up_request) state_d = ST_DISPATCH;
      ST_DISPATCH: state_d = hit_q ? ST_WAIT : ST_RESPOND;
      ST_WAIT:     if (sel_ack || (timer_q == 16'd0)) state_d = ST_RESPOND;
      ST_RESPOND:  state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    up_ack        = (state_q == ST_RESPOND);
    up_rdata      = (state_q == ST_RESPOND) ? rdata_q : 16'h0000;
    up_busy       = (state_q != ST_IDLE);
    dev_request   = ((state_q == ST_DISPATCH) && hit_q) ? match_q : '0;
    dev_write     = write_q;
    dev_address   = address_q;
    dev_wdata     = wdata_q;
    timeout_count = timeout_count_q;
  end

  // A same-cycle ack beats the timer reaching zero and is not counted as a timeout.
  always_comb begin
    write_d         = write_q;
    address_d       = address_q;
    wdata_d         = wdata_q;
    match_d         = match_q;
    sel_d           = sel_q;
    hit_d           = hit_q;
    timer_d         = timer_q;
    rdata_d         = rdata_q;
    timeout_count_d = timeout_count_q;
    case (state_q)
      ST_IDLE: begin
        if (up_request) begin
          write_d   = up_write;
          address_d = up_address;
          wdata_d   = up_wdata;
          match_d   = dec_match;
          sel_d     = dec_index;
          hit_d     = dec_hit;
        end
      end
      ST_DISPATCH: begin
        timer_d = TIMER_LOAD;
        if (!hit_q) rdata_d = open_bus;
      end
      ST_WAIT: begin
        if (sel_ack) begin
          rdata_d = write_q ? 16'h0000 : sel_rdata;
        end else if (timer_q == 16'd0) begin
          rdata_d = open_bus;
          if (timeout_count_q != 16'hFFFF) timeout_count_d = timeout_count_q + 16'd1;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      write_q         <= 1'b0;
      address_q       <= 32'h0;
      wdata_q         <= 16'h0;
      match_q         <= '0;
      sel_q           <= '0;
      hit_q           <= 1'b0;
      timer_q         <= 16'h0;
      rdata_q         <= 16'h0;
      timeout_count_q <= 16'h0;
    end else begin
      write_q         <= write_d;
      address_q       <= address_d;
      wdata_q         <= wdata_d;
      match_q         <= match_d;
      sel_q           <= sel_d;
      hit_q           <= hit_d;
      timer_q         <= timer_d;
      rdata_q         <= rdata_d;
      timeout_count_q <= timeout_count_d;
    end
  end

endmodule

// File: tb/tb_n64_bus_router.sv
// Bench for n64_bus_router: a transaction-timing model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_n64_bus_router;
  import sc64::*;

  localparam int NDEV = 6;
  localparam int TMO  = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NDEV-1:0]       dev_enable;
  logic                  up_request;
  logic                  up_write;
  logic [31:0]           up_address;
  logic [15:0]           up_wdata;
  logic                  up_ack;
  logic [15:0]           up_rdata;
  logic                  up_busy;
  logic [NDEV-1:0]       dev_request;
  logic                  dev_write;
  logic [31:0]           dev_address;
  logic [15:0]           dev_wdata;
  logic [NDEV-1:0]       dev_ack;
  logic [NDEV-1:0][15:0] dev_rdata;
  logic [15:0]           timeout_count;

  n64_bus_router #(
    .NUM_DEVICES    (NDEV),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .dev_enable    (dev_enable),
    .up_request    (up_request),
    .up_write      (up_write),
    .up_address    (up_address),
    .up_wdata      (up_wdata),
    .up_ack        (up_ack),
    .up_rdata      (up_rdata),
    .up_busy       (up_busy),
    .dev_request   (dev_request),
    .dev_write     (dev_write),
    .dev_address   (dev_address),
    .dev_wdata     (dev_wdata),
    .dev_ack       (dev_ack),
    .dev_rdata     (dev_rdata),
    .timeout_count (timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int ack_seen = 0;
  bit check_en = 1'b0;

  // Model state: one outstanding transaction described by its timing.
  bit          m_active = 1'b0;
  bit          m_mapped;
  int          m_acc, m_resp, m_wend, m_sel;
  logic [15:0] m_data;
  logic [15:0] m_count = 16'h0;
  logic        m_write = 1'b0;
  logic [31:0] m_addr  = 32'h0;
  logic [15:0] m_wdata = 16'h0;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    else
      n_pass++;
  endtask

  function automatic int model_select(input logic [31:0] addr, input logic [NDEV-1:0] en);
    for (int i = 0; i < NDEV; i++)
      if (en[i] && ((addr & DEFAULT_REGION_MASK[i]) == DEFAULT_REGION_BASE[i])) return i;
    return -1;
  endfunction

  // Inputs of cycle cyc are consumed at the edge that ends it.
  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_active = 1'b0;
        m_count  = 16'h0;
        m_write  = 1'b0;
        m_addr   = 32'h0;
        m_wdata  = 16'h0;
      end else if (m_active) begin
        if (m_mapped && m_resp < 0 && cyc >= m_acc + 2) begin
          if (dev_ack[m_sel]) begin
            m_resp = cyc + 1;
            m_data = m_write ? 16'h0 : dev_rdata[m_sel];
          end else if (cyc == m_wend) begin
            m_resp = cyc + 1;
            m_data = m_write ? 16'h0 : m_addr[15:0];
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          end
        end
        if (cyc == m_resp) m_active = 1'b0;
      end else if (up_request) begin
        m_active = 1'b1;
        m_acc    = cyc;
        m_write  = up_write;
        m_addr   = up_address;
        m_wdata  = up_wdata;
        m_sel    = model_select(up_address, dev_enable);
        m_mapped = (m_sel >= 0);
        m_wend   = cyc + 2 + TMO;
        if (m_mapped) begin
          m_resp = -1;
        end else begin
          m_resp = cyc + 2;
          m_data = up_write ? 16'h0 : up_address[15:0];
        end
      end
      cyc++;
    end
  end

  initial begin
    logic        e_ack;
    logic [31:0] e_req;
    forever begin
      @(negedge clk);
      if (up_ack === 1'b1) ack_seen++;
      if (check_en) begin
        e_ack = m_active && (m_resp == cyc);
        e_req = (m_active && m_mapped && cyc == m_acc + 1) ? (32'h1 << m_sel) : 32'h0;
        check_output("m_up_ack", {31'h0, up_ack}, {31'h0, e_ack});
        check_output("m_up_rdata", {16'h0, up_rdata}, e_ack ? {16'h0, m_data} : 32'h0);
        check_output("m_up_busy", {31'h0, up_busy}, {31'h0, m_active});
        check_output("m_dev_request", {26'h0, dev_request}, e_req);
        check_output("m_dev_write", {31'h0, dev_write}, {31'h0, m_write});
        check_output("m_dev_address", dev_address, m_addr);
        check_output("m_dev_wdata", {16'h0, dev_wdata}, {16'h0, m_wdata});
        check_output("m_timeout_count", {16'h0, timeout_count}, {16'h0, m_count});
      end
    end
  end

  task automatic goto_cycle(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic wr, input logic [31:0] addr, input logic [15:0] wd,
                                output int acc);
    acc        = cyc;
    up_request = 1'b1;
    up_write   = wr;
    up_address = addr;
    up_wdata   = wd;
    @(posedge clk);
    #1;
    up_request = 1'b0;
  endtask

  task automatic drive_ack(input int dev, input logic [15:0] data, input int at);
    goto_cycle(at);
    dev_ack        = '0;
    dev_ack[dev]   = 1'b1;
    dev_rdata[dev] = data;
    goto_cycle(at + 1);
    dev_ack = '0;
  endtask

  task automatic wait_ack(output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (up_ack === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) check_output("ack_wait_expired", 32'h0, 32'h1);
  endtask

  initial begin
    int a, t, snap;
    reset      = 1'b1;
    dev_enable = '1;
    up_request = 1'b0;
    up_write   = 1'b0;
    up_address = 32'h0;
    up_wdata   = 16'h0;
    dev_ack    = '0;
    dev_rdata  = '0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(negedge clk);
    check_output("rst_busy", {31'h0, up_busy}, 32'h0);
    check_output("rst_timeout_count", {16'h0, timeout_count}, 32'h0);
    check_output("rst_dev_request", {26'h0, dev_request}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    goto_cycle(cyc + 2);

    $display("[TB] read device 0, ack 3 cycles after dev_request");
    apply_stimulus(1'b0, 32'h1000_0000, 16'h0, a);
    @(negedge clk);
    check_output("t1_dev_request", {26'h0, dev_request}, 32'h01);
    drive_ack(0, 16'hBEEF, a + 4);
    wait_ack(t);
    check_output("t1_ack_cycle", t, a + 5);
    check_output("t1_rdata", {16'h0, up_rdata}, 32'hBEEF);
    goto_cycle(cyc + 2);

    $display("[TB] minimum latency read");
    apply_stimulus(1'b0, 32'h1000_0040, 16'h0, a);
    drive_ack(0, 16'h1357, a + 2);
    wait_ack(t);
    check_output("t2_ack_cycle", t, a + 3);
    check_output("t2_rdata", {16'h0, up_rdata}, 32'h1357);
    goto_cycle(cyc + 2);

    $display("[TB] unmapped access");
    apply_stimulus(1'b0, 32'h1FFE_1234, 16'h0, a);
    @(negedge clk);
    check_output("t3_dev_request", {26'h0, dev_request}, 32'h0);
    wait_ack(t);
    check_output("t3_ack_cycle", t, a + 2);
    check_output("t3_rdata", {16'h0, up_rdata}, 32'h1234);
    goto_cycle(cyc + 2);

    $display("[TB] silent device times out, late ack discarded");
    apply_stimulus(1'b0, 32'h0800_0100, 16'h0, a);
    wait_ack(t);
    check_output("t4_ack_cycle", t, a + 3 + TMO);
    check_output("t4_rdata", {16'h0, up_rdata}, 32'h0100);
    dev_ack[4]   = 1'b1;
    dev_rdata[4] = 16'h7777;
    goto_cycle(t + 1);
    snap = ack_seen;
    goto_cycle(t + 2);
    dev_ack = '0;
    goto_cycle(t + 7);
    check_output("t4_late_ack_ignored", ack_seen - snap, 32'h0);
    check_output("t4_timeout_count", {16'h0, timeout_count}, 32'h1);

    $display("[TB] ack on the last timer cycle is a normal completion");
    apply_stimulus(1'b0, 32'h1800_0000, 16'h0, a);
    drive_ack(2, 16'h5A5A, a + 2 + TMO);
    wait_ack(t);
    check_output("t5_ack_cycle", t, a + 3 + TMO);
    check_output("t5_rdata", {16'h0, up_rdata}, 32'h5A5A);
    @(negedge clk);
    check_output("t5_timeout_count", {16'h0, timeout_count}, 32'h1);
    goto_cycle(cyc + 2);

    $display("[TB] overlapping regions 1 and 3");
    dev_enable = 6'b111101;
    apply_stimulus(1'b0, 32'h1FFF_0010, 16'h0, a);
    @(negedge clk);
    check_output("t6_sel_dev3", {26'h0, dev_request}, 32'h08);
    drive_ack(1, 16'hDEAD, a + 2);
    drive_ack(3, 16'h3333, a + 3);
    wait_ack(t);
    check_output("t6_ack_cycle", t, a + 4);
    check_output("t6_rdata", {16'h0, up_rdata}, 32'h3333);
    goto_cycle(cyc + 2);
    dev_enable = '1;
    apply_stimulus(1'b0, 32'h1FFF_0010, 16'h0, a);
    @(negedge clk);
    check_output("t6_sel_dev1", {26'h0, dev_request}, 32'h02);
    drive_ack(1, 16'h1111, a + 2);
    wait_ack(t);
    check_output("t6b_rdata", {16'h0, up_rdata}, 32'h1111);
    goto_cycle(cyc + 2);

    $display("[TB] reset during WAIT, then a write");
    apply_stimulus(1'b0, 32'h1000_0000, 16'h0, a);
    goto_cycle(a + 3);
    reset = 1'b1;
    snap  = ack_seen;
    goto_cycle(a + 4);
    reset = 1'b0;
    @(negedge clk);
    check_output("t7_busy_after_reset", {31'h0, up_busy}, 32'h0);
    check_output("t7_address_cleared", dev_address, 32'h0);
    check_output("t7_count_cleared", {16'h0, timeout_count}, 32'h0);
    goto_cycle(a + 10);
    check_output("t7_no_late_ack", ack_seen - snap, 32'h0);
    apply_stimulus(1'b1, 32'h1000_0002, 16'h0055, a);
    @(negedge clk);
    check_output("t7_dev_wdata", {16'h0, dev_wdata}, 32'h0055);
    check_output("t7_dev_write", {31'h0, dev_write}, 32'h1);
    drive_ack(0, 16'hFFFF, a + 2);
    wait_ack(t);
    check_output("t7_write_rdata", {16'h0, up_rdata}, 32'h0);
    goto_cycle(cyc + 2);

    $display("[TB] second request during WAIT is dropped");
    apply_stimulus(1'b0, 32'h0500_0000, 16'h0, a);
    snap = ack_seen;
    goto_cycle(a + 3);
    up_request = 1'b1;
    up_address = 32'h1000_0000;
    goto_cycle(a + 4);
    up_request = 1'b0;
    drive_ack(5, 16'h4242, a + 5);
    wait_ack(t);
    check_output("t8_rdata", {16'h0, up_rdata}, 32'h4242);
    goto_cycle(a + 14);
    check_output("t8_single_ack", ack_seen - snap, 32'h1);
    check_output("t8_dev_address", dev_address, 32'h0500_0000);

    goto_cycle(cyc + 3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/n64_bus_router.md
N64_BUS_ROUTER -- requirements
Module: n64_bus_router

Interface
REQ-001 SHALL have parameter NUM_DEVICES, default 6, meaning number of downstream device ports (1..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning device-ack wait limit in clk cycles (1..65535).
REQ-003 SHALL have parameters REGION_BASE / REGION_MASK, each NUM_DEVICES x 32-bit, default taken from the package map, meaning device i matches when (address & REGION_MASK[i]) == REGION_BASE[i].
REQ-004 SHALL have one clock and a synchronous, active-high reset, exposed as the ports below.
REQ-005 clk  in  1  system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 dev_enable  in  NUM_DEVICES  per-device enable from configuration; a disabled device never matches.
REQ-008 up_request  in  1  single-cycle upstream (PI) access strobe.
REQ-009 up_write  in  1  1 = write, 0 = read; sampled with up_request.
REQ-010 up_address  in  32  byte address; sampled with up_request.
REQ-011 up_wdata  in  16  write data; sampled with up_request.
REQ-012 up_ack  out  1  single-cycle completion strobe.
REQ-013 up_rdata  out  16  read data; valid only while up_ack = 1.
REQ-014 up_busy  out  1  high from the cycle after acceptance until the cycle after up_ack.
REQ-015 dev_request  out  NUM_DEVICES  one-hot single-cycle strobe to the selected device.
REQ-016 dev_write / dev_address / dev_wdata  out  1 / 32 / 16  registered copies, broadcast to all devices.
REQ-017 dev_ack  in  NUM_DEVICES  per-device single-cycle completion.
REQ-018 dev_rdata  in  NUM_DEVICES x 16  per-device read data, valid with dev_ack.
REQ-019 timeout_count  out  16  saturating count of timed-out accesses.

Function
REQ-020 SHALL implement states IDLE, DISPATCH, WAIT, RESPOND.
REQ-021 IDLE: on up_request, SHALL latch write/address/wdata and decode, then go to DISPATCH (cycle 1).
REQ-022 Decode: among enabled matching regions, SHALL select the lowest index; none matching = unmapped.
REQ-023 DISPATCH, mapped: SHALL pulse dev_request[sel] for exactly one cycle, load timer = TIMEOUT_CYCLES, and go to WAIT.
REQ-024 DISPATCH, unmapped: SHALL go to RESPOND with rdata = address[15:0] (open-bus value), with no dev_request.
REQ-025 WAIT: on dev_ack[sel], SHALL capture dev_rdata[sel] and go to RESPOND; dev_ack from non-selected ports SHALL be ignored.
REQ-026 WAIT: the timer SHALL decrement each cycle without ack; at 0 it SHALL go to RESPOND with rdata = address[15:0] and increment timeout_count, holding it at 0xFFFF.
REQ-027 Ack in the same cycle that the timer reaches 0 SHALL win; this is a normal completion and SHALL NOT be counted.
REQ-028 RESPOND: SHALL pulse up_ack for one cycle with up_rdata, then go to IDLE. A dev_ack arriving after a timeout SHALL be discarded.
REQ-029 Minimum latency: request at cycle 0, dev_request at cycle 1, dev_ack at cycle 2, up_ack at cycle 3; unmapped up_ack at cycle 2.
REQ-030 up_request while not IDLE SHALL be dropped, with no state change.
REQ-031 For writes, up_rdata SHALL be 0.

Reset
REQ-032 Reset SHALL force IDLE, clear dev_request, up_ack, up_busy and timeout_count, and zero up_rdata and the dev_* registers; a mid-access reset SHALL abandon the access without a late up_ack.

Structure
REQ-033 Package sc64 SHALL hold the device-ID enumeration, the default REGION_BASE/REGION_MASK map, and the state typedef.
REQ-034 The address decoder SHALL be a sub-module, n64_bus_decoder: combinational, parametrised by NUM_DEVICES, outputting a one-hot match and an index.

Verification
REQ-035 Read 0x10000000 to device 0 acking 3 cycles after dev_request with 0xBEEF -> up_ack 1 cycle later, up_rdata 0xBEEF, dev_request one-hot 0x01.
REQ-036 Access 0x1FFE1234 with no region matching -> up_ack at cycle 2, up_rdata 0x1234, dev_request 0.
REQ-037 TIMEOUT_CYCLES = 4 and a silent device -> up_ack with up_rdata = address[15:0], timeout_count 1; a late dev_ack is ignored and produces no second up_ack.
REQ-038 Overlapping regions 1 and 3 with dev_enable[1] = 0 -> device 3 selected; with both enabled -> device 1 selected.
REQ-039 Reset asserted in WAIT -> next cycle IDLE, no up_ack; then a write 0x0055 -> dev_wdata 0x0055, dev_write 1, up_rdata 0.
REQ-040 Second up_request during WAIT -> dropped; exactly one up_ack.
